// File: rtl/game_rate_if.sv
// Handshake bundle between the rate controller and its neighbours: buttons,
// score pulses and the returned game clock in; rate select and strobes out.
interface game_rate_if;
  logic       btn_up;
  logic       btn_down;
  logic       score_tick;
  logic       clk_game;
  logic [1:0] clk_rate;
  logic       rate_pending;
  logic       game_step;

  modport master (
    output btn_up, btn_down, score_tick, clk_game,
    input  clk_rate, rate_pending, game_step
  );

  modport slave (
    input  btn_up, btn_down, score_tick, clk_game,
    output clk_rate, rate_pending, game_step
  );
endinterface

// File: rtl/game_rate_ctrl.sv
// Game rate controller: debounced speed buttons set a target rate that is
// applied to the divider only on a clk_game rising edge. Score-driven
// auto-speedup is built only when GAME_RATE_AUTO_SPEEDUP_EN is defined.
module game_rate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCORE_PER_LEVEL = 16,
  parameter int CNT_W           = 20
) (
  input  logic      clk,
  input  logic      rst_n,
  game_rate_if.slave bus
);

  localparam int NB = 2;  // bit 0 = up, bit 1 = down

  typedef enum logic {IDLE, PENDING} state_t;

  logic [NB-1:0]            btn_s1, btn_s2, lvl, lvl_d, evt;
  logic [NB-1:0][CNT_W-1:0] cnt;
  logic                     up_evt, down_evt, lvl_evt;
  logic                     g_s1, g_s2, g_prev, game_edge, game_step;
  logic [1:0]               target, target_nxt, clk_rate, clk_rate_nxt;
  logic                     rate_pending, load;
  int                       sum;
  state_t                   state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= {bus.btn_down, bus.btn_up};
      btn_s2 <= btn_s1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      lvl   <= '0;
      lvl_d <= '0;
    end else begin
      lvl_d <= lvl;
      for (int b = 0; b < NB; b++) begin
        if (btn_s2[b] == lvl[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl[b] <= btn_s2[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  assign evt      = lvl & ~lvl_d;
  assign up_evt   = evt[0];
  assign down_evt = evt[1];

`ifdef GAME_RATE_AUTO_SPEEDUP_EN
  localparam int SC_W = (SCORE_PER_LEVEL > 1) ? $clog2(SCORE_PER_LEVEL) : 1;
  logic [SC_W-1:0] score_cnt;
  logic            score_wrap;

  assign score_wrap = (score_cnt == SC_W'(SCORE_PER_LEVEL - 1));
  assign lvl_evt    = bus.score_tick & score_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              score_cnt <= '0;
    else if (bus.score_tick) score_cnt <= score_wrap ? '0 : score_cnt + 1'b1;
  end
`else
  logic unused_score_tick;
  assign unused_score_tick = bus.score_tick;
  assign lvl_evt           = 1'b0;
`endif

  always_comb begin
    sum = int'(target) + int'(up_evt) + int'(lvl_evt) - int'(down_evt);
    if (sum < 0)      target_nxt = 2'd0;
    else if (sum > 3) target_nxt = 2'd3;
    else              target_nxt = 2'(sum);
  end

  // game_edge is registered so the strobe lands a fixed 4 clk after clk_game rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_s1      <= 1'b0;
      g_s2      <= 1'b0;
      g_prev    <= 1'b0;
      game_edge <= 1'b0;
      game_step <= 1'b0;
    end else begin
      g_s1      <= bus.clk_game;
      g_s2      <= g_s1;
      g_prev    <= g_s2;
      game_edge <= g_s2 & ~g_prev;
      game_step <= game_edge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (target != clk_rate) state_nxt = PENDING;
      PENDING: if (target == clk_rate || game_edge) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load         = (state == PENDING) && (target != clk_rate) && game_edge;
    clk_rate_nxt = load ? target : clk_rate;
  end

  // rate_pending tracks the post-update mismatch so it is clear right after a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target       <= 2'd0;
      clk_rate     <= 2'd0;
      rate_pending <= 1'b0;
    end else begin
      target       <= target_nxt;
      clk_rate     <= clk_rate_nxt;
      rate_pending <= (target_nxt != clk_rate_nxt);
    end
  end

  assign bus.clk_rate     = clk_rate;
  assign bus.rate_pending = rate_pending;
  assign bus.game_step    = game_step;

endmodule
